// File: rtl/rps_pkg.sv
// Shared move/result codes, FSM state encoding and the move-ordering rule
// for the stone-paper-scissors match controller.
package rps_pkg;

  typedef enum logic [1:0] {
    MV_STONE    = 2'b00,
    MV_PAPER    = 2'b01,
    MV_SCISSORS = 2'b10,
    MV_INVALID  = 2'b11
  } move_e;

  // Match winner reuses the first three codes: 00 draw/none, 01 P1, 10 P2.
  typedef enum logic [1:0] {
    RES_TIE  = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_VOID = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    ST_ROUND = 2'b00,
    ST_EVAL  = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // True when valid move a defeats valid move b.
  function automatic logic beats(input move_e a, input move_e b);
    logic win;
    win = 1'b0;
    case (a)
      MV_STONE:    win = (b == MV_SCISSORS);
      MV_PAPER:    win = (b == MV_STONE);
      MV_SCISSORS: win = (b == MV_PAPER);
      default:     win = 1'b0;
    endcase
    return win;
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: maps two moves to a round result and whether
// the round counts toward the match round total.
module rps_judge
  import rps_pkg::*;
#(
  parameter bit INVALID_FORFEIT = 1'b1
) (
  input  move_e   p1_move,
  input  move_e   p2_move,
  output result_e result,
  output logic    counted
);

  // NOTE: every output gets a default before any branch so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    result  = RES_VOID;
    counted = 1'b0;
    if (p1_move == MV_INVALID && p2_move == MV_INVALID) begin
      result  = RES_VOID;
      counted = 1'b0;
    end else if (p1_move == MV_INVALID) begin
      if (INVALID_FORFEIT) begin
        result  = RES_P2;
        counted = 1'b1;
      end
    end else if (p2_move == MV_INVALID) begin
      if (INVALID_FORFEIT) begin
        result  = RES_P1;
        counted = 1'b1;
      end
    end else if (p1_move == p2_move) begin
      result  = RES_TIE;
      counted = 1'b1;
    end else begin
      result  = beats(p1_move, p2_move) ? RES_P1 : RES_P2;
      counted = 1'b1;
    end
  end

endmodule

// File: rtl/rps_match_ctrl.sv
// First-to-WIN_TARGET stone-paper-scissors match controller with a round cap,
// start edge capture, one-cycle judging and match winner declaration.
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int  WIN_TARGET      = 3,
  parameter int  MAX_ROUNDS      = 9,
  parameter bit  INVALID_FORFEIT = 1'b1,
  localparam int SCORE_W         = $clog2(WIN_TARGET + 1),
  localparam int RND_W           = $clog2(MAX_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               clear,
  input  logic               start,
  input  logic [1:0]         p1_move,
  input  logic [1:0]         p2_move,
  output logic [1:0]         round_result,
  output logic               result_valid,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [RND_W-1:0]   round_cnt,
  output logic               match_done,
  output logic [1:0]         match_winner,
  output logic               busy
);

  state_e             state_q, state_d;
  logic               start_q, start_d;
  move_e              p1_mv_q, p1_mv_d;
  move_e              p2_mv_q, p2_mv_d;
  result_e            result_q, result_d;
  logic               valid_q, valid_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d;
  logic [SCORE_W-1:0] p2_score_q, p2_score_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  result_e            winner_q, winner_d;

  result_e            judge_result;
  logic               judge_counted;
  logic               start_edge;

  rps_judge #(
    .INVALID_FORFEIT(INVALID_FORFEIT)
  ) u_judge (
    .p1_move(p1_mv_q),
    .p2_move(p2_mv_q),
    .result (judge_result),
    .counted(judge_counted)
  );

  assign start_edge = start & ~start_q & ena;

  always_comb begin
    logic [SCORE_W-1:0] p1_nxt;
    logic [SCORE_W-1:0] p2_nxt;
    logic [RND_W-1:0]   rnd_nxt;

    state_d    = state_q;
    start_d    = start_q;
    p1_mv_d    = p1_mv_q;
    p2_mv_d    = p2_mv_q;
    result_d   = result_q;
    valid_d    = 1'b0;
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    rnd_d      = rnd_q;
    winner_d   = winner_q;

    // Scores after applying the judged round; only consumed in EVAL.
    p1_nxt  = p1_score_q;
    p2_nxt  = p2_score_q;
    rnd_nxt = rnd_q;
    if (judge_counted) begin
      rnd_nxt = rnd_q + RND_W'(1);
      if (judge_result == RES_P1) p1_nxt = p1_score_q + SCORE_W'(1);
      if (judge_result == RES_P2) p2_nxt = p2_score_q + SCORE_W'(1);
    end

    if (clear) begin
      start_d    = start;
      state_d    = ST_ROUND;
      result_d   = RES_TIE;
      p1_score_d = '0;
      p2_score_d = '0;
      rnd_d      = '0;
      winner_d   = RES_TIE;
    end else if (ena) begin
      start_d = start;
      case (state_q)
        ST_ROUND: begin
          if (start_edge) begin
            p1_mv_d = move_e'(p1_move);
            p2_mv_d = move_e'(p2_move);
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          valid_d    = 1'b1;
          result_d   = judge_result;
          p1_score_d = p1_nxt;
          p2_score_d = p2_nxt;
          rnd_d      = rnd_nxt;
          state_d    = ST_ROUND;
          if (p1_nxt == SCORE_W'(WIN_TARGET) || p2_nxt == SCORE_W'(WIN_TARGET) ||
              rnd_nxt == RND_W'(MAX_ROUNDS)) begin
            state_d = ST_DONE;
            // A player at target wins outright; otherwise this is the round cap.
            if (p1_nxt == SCORE_W'(WIN_TARGET))      winner_d = RES_P1;
            else if (p2_nxt == SCORE_W'(WIN_TARGET)) winner_d = RES_P2;
            else if (p1_nxt > p2_nxt)                winner_d = RES_P1;
            else if (p2_nxt > p1_nxt)                winner_d = RES_P2;
            else                                     winner_d = RES_TIE;
          end
        end
        ST_DONE: begin
          if (start_edge) begin
            state_d    = ST_ROUND;
            result_d   = RES_TIE;
            p1_score_d = '0;
            p2_score_d = '0;
            rnd_d      = '0;
            winner_d   = RES_TIE;
          end
        end
        default: state_d = ST_ROUND;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ROUND;
      start_q    <= 1'b0;
      p1_mv_q    <= MV_STONE;
      p2_mv_q    <= MV_STONE;
      result_q   <= RES_TIE;
      valid_q    <= 1'b0;
      p1_score_q <= '0;
      p2_score_q <= '0;
      rnd_q      <= '0;
      winner_q   <= RES_TIE;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      p1_mv_q    <= p1_mv_d;
      p2_mv_q    <= p2_mv_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      p1_score_q <= p1_score_d;
      p2_score_q <= p2_score_d;
      rnd_q      <= rnd_d;
      winner_q   <= winner_d;
    end
  end

  assign round_result = result_q;
  assign result_valid = valid_q;
  assign p1_score     = p1_score_q;
  assign p2_score     = p2_score_q;
  assign round_cnt    = rnd_q;
  assign match_done   = (state_q == ST_DONE);
  assign match_winner = winner_q;
  assign busy         = (state_q == ST_EVAL);

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Self-checking bench: two controllers (forfeit on / replay on invalid) driven
// by directed and random rounds, compared against a round-level match model.
module tb_rps_match_ctrl;

  localparam int WIN  = 3;
  localparam int MAXR = 9;
  localparam int SW   = 2;
  localparam int RW   = 4;

  logic          clk;
  logic          rst_n;
  logic          ena;
  logic          clear;
  logic          start_v      [2];
  logic [1:0]    p1_v         [2];
  logic [1:0]    p2_v         [2];
  logic [1:0]    round_result [2];
  logic          result_valid [2];
  logic [SW-1:0] p1_score     [2];
  logic [SW-1:0] p2_score     [2];
  logic [RW-1:0] round_cnt    [2];
  logic          match_done   [2];
  logic [1:0]    match_winner [2];
  logic          busy         [2];

  int checks;
  int failures;

  typedef struct {
    int s1;
    int s2;
    int rnd;
    int res;
    int win;
    bit done;
  } mdl_t;

  mdl_t m [2];

  rps_match_ctrl u_dut_f (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .start(start_v[0]),
    .p1_move(p1_v[0]), .p2_move(p2_v[0]), .round_result(round_result[0]),
    .result_valid(result_valid[0]), .p1_score(p1_score[0]), .p2_score(p2_score[0]),
    .round_cnt(round_cnt[0]), .match_done(match_done[0]),
    .match_winner(match_winner[0]), .busy(busy[0])
  );

  rps_match_ctrl #(.INVALID_FORFEIT(1'b0)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .start(start_v[1]),
    .p1_move(p1_v[1]), .p2_move(p2_v[1]), .round_result(round_result[1]),
    .result_valid(result_valid[1]), .p1_score(p1_score[1]), .p2_score(p2_score[1]),
    .round_cnt(round_cnt[1]), .match_done(match_done[1]),
    .match_winner(match_winner[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One round in match terms: moves 0 stone, 1 paper, 2 scissors, 3 invalid.
  function automatic mdl_t mdl_play(input mdl_t cur, input int a, input int b, input bit forfeit);
    mdl_t n;
    int   res;
    bit   counted;
    n = cur;
    if (cur.done) begin
      n = '{default: 0};
      return n;
    end
    counted = 1'b1;
    if (a == 3 && b == 3) begin
      res = 3; counted = 1'b0;
    end else if (a == 3 || b == 3) begin
      if (forfeit) res = (a == 3) ? 2 : 1;
      else begin res = 3; counted = 1'b0; end
    end else if (a == b) begin
      res = 0;
    end else begin
      res = ((a - b + 3) % 3 == 1) ? 1 : 2;
    end
    n.res = res;
    if (counted) begin
      n.rnd++;
      if (res == 1) n.s1++;
      if (res == 2) n.s2++;
    end
    if (n.s1 == WIN || n.s2 == WIN || n.rnd == MAXR) begin
      n.done = 1'b1;
      if (n.s1 == WIN)       n.win = 1;
      else if (n.s2 == WIN)  n.win = 2;
      else if (n.s1 > n.s2)  n.win = 1;
      else if (n.s2 > n.s1)  n.win = 2;
      else                   n.win = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input int i, input string tag, input mdl_t e, input bit vexp);
    check($sformatf("%s[%0d].valid", tag, i),  result_valid[i], vexp);
    check($sformatf("%s[%0d].result", tag, i), round_result[i], e.res);
    check($sformatf("%s[%0d].p1", tag, i),     p1_score[i], e.s1);
    check($sformatf("%s[%0d].p2", tag, i),     p2_score[i], e.s2);
    check($sformatf("%s[%0d].rnd", tag, i),    round_cnt[i], e.rnd);
    check($sformatf("%s[%0d].done", tag, i),   match_done[i], e.done);
    check($sformatf("%s[%0d].winner", tag, i), match_winner[i], e.win);
  endtask

  // Start edge with the given moves on instance i; moves are scrambled the
  // cycle after capture so the result must come from the latched values.
  task automatic play(input int i, input int a, input int b);
    mdl_t exp;
    bit   was_done;
    was_done = m[i].done;
    exp      = mdl_play(m[i], a, b, i == 0);
    @(negedge clk);
    p1_v[i]    = a[1:0];
    p2_v[i]    = b[1:0];
    start_v[i] = 1'b1;
    @(negedge clk);
    check($sformatf("eval_busy[%0d]", i), busy[i], !was_done);
    check($sformatf("pre_valid[%0d]", i), result_valid[i], 1'b0);
    start_v[i] = 1'b0;
    p1_v[i]    = 2'($urandom);
    p2_v[i]    = 2'($urandom);
    @(negedge clk);
    check_state(i, "round", exp, !was_done);
    check($sformatf("busy_off[%0d]", i), busy[i], 1'b0);
    m[i] = exp;
    @(negedge clk);
    check($sformatf("pulse_end[%0d]", i), result_valid[i], 1'b0);
  endtask

  initial begin
    mdl_t exp;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    ena        = 1'b1;
    clear      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      p1_v[i]    = 2'b00;
      p2_v[i]    = 2'b00;
      m[i]       = '{default: 0};
    end

    // Reset state
    #12;
    for (int i = 0; i < 2; i++) begin
      check_state(i, "reset", m[i], 1'b0);
      check($sformatf("reset_busy[%0d]", i), busy[i], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // P1 stone vs P2 scissors three times: P1 takes the match 3-0
    for (int k = 0; k < 3; k++) play(0, 0, 2);
    check("win3.done", match_done[0], 1'b1);
    check("win3.winner", match_winner[0], 2'b01);
    check("win3.rnd", round_cnt[0], 3);
    // Start edge in DONE clears without playing
    play(0, 1, 1);

    // Invalid P1 vs paper, then both invalid, on both forfeit settings
    play(0, 3, 1);
    play(1, 3, 1);
    play(0, 3, 3);
    play(1, 3, 3);
    play(1, 2, 1);

    // Clear coincident with a start edge: clear wins
    @(negedge clk);
    clear      = 1'b1;
    start_v[0] = 1'b1;
    p1_v[0]    = 2'b00;
    p2_v[0]    = 2'b10;
    @(negedge clk);
    clear      = 1'b0;
    start_v[0] = 1'b0;
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    for (int i = 0; i < 2; i++) begin
      check_state(i, "clear", m[i], 1'b0);
      check($sformatf("clear_busy[%0d]", i), busy[i], 1'b0);
    end
    @(negedge clk);
    check("clear_no_valid", result_valid[0], 1'b0);

    // Round cap: nine ties give a drawn match
    for (int k = 0; k < 9; k++) play(0, 0, 0);
    check("cap.rnd", round_cnt[0], 9);
    check("cap.done", match_done[0], 1'b1);
    check("cap.winner", match_winner[0], 2'b00);
    play(0, 0, 0);

    // start held high for many cycles plays exactly one round
    exp = mdl_play(m[0], 1, 0, 1'b1);
    @(negedge clk);
    p1_v[0]    = 2'b01;
    p2_v[0]    = 2'b00;
    start_v[0] = 1'b1;
    repeat (6) @(negedge clk);
    start_v[0] = 1'b0;
    m[0] = exp;
    check_state(0, "held", m[0], 1'b0);
    repeat (2) @(negedge clk);

    // Start pulse entirely inside an ena-low window is ignored
    ena = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    check_state(0, "ena_low", m[0], 1'b0);
    check("ena_low.busy", busy[0], 1'b0);

    // Asynchronous reset in the middle of EVAL
    @(negedge clk);
    p1_v[0]    = 2'b10;
    p2_v[0]    = 2'b01;
    start_v[0] = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mid.busy_before", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    check_state(0, "rst_mid", m[0], 1'b0);
    check("rst_mid.busy", busy[0], 1'b0);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random rounds on both controllers against the model
    for (int k = 0; k < 60; k++) begin
      play(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
